// File: rtl/bcd_conv_arbiter.sv
// Round-robin sequencer sharing one binary-to-BCD converter among NUM_REQ requesters.
// Each request is latched, issued through a start/ready/done handshake, and guarded by a timeout.
//
// state   | meaning
// S_IDLE  | no request in flight; picks the next pending requester round-robin
// S_ISSUE | operand on conv_bin_o, waiting for conv_ready_i to fire conv_start_o
// S_WAIT  | converter busy; timer counts toward the hang timeout
// S_RESP  | one-cycle result pulse to the granted requester
module bcd_conv_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int MAX_VAL        = 9999
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_REQ-1:0]    req_start_i,
  input  logic [13:0]           req_bin_i [NUM_REQ],
  output logic [NUM_REQ-1:0]    req_ready_o,
  output logic [NUM_REQ-1:0]    resp_valid_o,
  output logic                  resp_err_o,
  output logic [3:0][3:0]       resp_bcd_o,
  output logic                  conv_start_o,
  output logic [13:0]           conv_bin_o,
  input  logic                  conv_ready_i,
  input  logic                  conv_done_i,
  input  logic [3:0][3:0]       conv_bcd_i
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0] LAST_REQ   = PW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            state_q;
  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic [13:0]       op_q [NUM_REQ];
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]     grant_q, grant_sel;
  logic [TW-1:0]     timer_q;
  logic [13:0]       conv_bin_q;
  logic [3:0][3:0]   resp_bcd_q;
  logic              resp_err_q;

  function automatic logic [13:0] sat14(input logic [13:0] v);
    return ({18'd0, v} >= 32'(MAX_VAL + 1)) ? 14'(MAX_VAL) : v;
  endfunction

  // Lowest rotation offset from rr_ptr wins, so scan offsets high to low.
  always_comb begin
    grant_sel = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int idx;
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (pending_q[PW'(idx)]) grant_sel = PW'(idx);
    end
  end

  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_start_i[i] && !pending_q[i]) pending_d[i] = 1'b1;
    end
    if (state_q == S_RESP) pending_d[grant_q] = 1'b0;
  end

  assign rr_ptr_d = (grant_q == LAST_REQ) ? '0 : grant_q + PW'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      pending_q  <= '0;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      timer_q    <= '0;
      conv_bin_q <= '0;
      resp_bcd_q <= '0;
      resp_err_q <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) op_q[i] <= '0;
    end else begin
      pending_q <= pending_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_start_i[i] && !pending_q[i]) op_q[i] <= sat14(req_bin_i[i]);
      end

      case (state_q)
        S_IDLE: begin
          if (|pending_q) begin
            grant_q    <= grant_sel;
            conv_bin_q <= op_q[grant_sel];
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (conv_ready_i) begin
            timer_q <= '0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A done arriving on the timeout cycle still counts as a good result.
          if (conv_done_i) begin
            resp_bcd_q <= conv_bcd_i;
            resp_err_q <= 1'b0;
            state_q    <= S_RESP;
          end else if (timer_q == TIMER_LAST) begin
            resp_bcd_q <= '0;
            resp_err_q <= 1'b1;
            state_q    <= S_RESP;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_RESP: begin
          rr_ptr_q <= rr_ptr_d;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    resp_valid_o = '0;
    if (state_q == S_RESP) resp_valid_o[grant_q] = 1'b1;
  end

  assign req_ready_o  = ~pending_q;
  assign conv_start_o = (state_q == S_ISSUE) && conv_ready_i;
  assign conv_bin_o   = conv_bin_q;
  assign resp_bcd_o   = resp_bcd_q;
  assign resp_err_o   = resp_err_q;

endmodule
